// File: rtl/round_robin_arbiter16.sv
// round_robin_arbiter16: 16-way round-robin arbiter with held grants, registered outputs
// and an optional hold limit that forces release and pulses timeout_o.
`default_nettype none

module round_robin_arbiter16 #(
    parameter int HOLD_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [15:0] req_i,
    input  logic        release_i,
    output logic [15:0] grant_o,
    output logic [3:0]  grant_id_o,
    output logic        grant_valid_o,
    output logic        timeout_o
);

    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    logic [3:0]         ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        grant_q;
    logic [3:0]         grant_id_q;
    logic               grant_valid_q;
    logic               timeout_q;

    logic [3:0]         win_id;
    logic               win_vld;
    logic               expire;
    logic               normal_end;

    // Walk offsets from high to low so the nearest set bit after ptr_q overwrites the rest.
    always_comb begin
        win_id  = 4'd0;
        win_vld = |req_i;
        for (int i = 15; i >= 0; i--) begin
            if (req_i[ptr_q + 4'(i)]) begin
                win_id = ptr_q + 4'(i);
            end
        end
    end

    generate
        if (HOLD_MAX > 0) begin : g_hold_limit
            assign expire = (cnt_q == CNT_W'(HOLD_MAX - 1));
        end else begin : g_no_hold_limit
            assign expire = 1'b0;
        end
    endgenerate

    assign normal_end = release_i || !req_i[grant_id_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= 4'd0;
            cnt_q         <= '0;
            grant_q       <= 16'd0;
            grant_id_q    <= 4'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timeout_q <= 1'b0;
                    if (enable_i && win_vld) begin
                        state_q       <= S_BUSY;
                        grant_q       <= 16'd1 << win_id;
                        grant_id_q    <= win_id;
                        grant_valid_q <= 1'b1;
                        cnt_q         <= '0;
                    end
                end
                S_BUSY: begin
                    if (normal_end || expire) begin
                        state_q       <= S_IDLE;
                        grant_q       <= 16'd0;
                        grant_id_q    <= 4'd0;
                        grant_valid_q <= 1'b0;
                        ptr_q         <= grant_id_q + 4'd1;
                        cnt_q         <= '0;
                        // A voluntary end in the expiry cycle is not a timeout.
                        timeout_q     <= !normal_end;
                    end else if (HOLD_MAX != 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_id_o    = grant_id_q;
    assign grant_valid_o = grant_valid_q;
    assign timeout_o     = timeout_q;

endmodule

`default_nettype wire
